// File: rtl/key_debounce.sv
// Push-button debouncer with 2-flop synchronizer, press/release/long-press pulses.
// All outputs are registered and reflect the FSM state after each rising edge.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 240_000,
    parameter int LONG_CYC     = 12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int LW = $clog2(LONG_CYC);

    // Transition fires on the cycle the counter would reach DEBOUNCE_CYC-1,
    // so the FSM observes DEBOUNCE_CYC consecutive stable samples in total.
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 2);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);
    localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYC - 2);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            key_meta;
    logic            key_s;
    logic [DW-1:0]   deb_cnt;
    logic [DW-1:0]   deb_next;
    logic [LW-1:0]   long_cnt;
    logic [LW-1:0]   long_next;
    logic            press_d;
    logic            release_d;
    logic            long_d;
    logic            level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_s    <= key_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            long_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_next;
            deb_cnt     <= deb_next;
            long_cnt    <= long_next;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
        end
    end

    always_comb begin
        state_next = state;
        deb_next   = deb_cnt;
        long_next  = long_cnt;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_next = PRESS_WAIT;
                    deb_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_next = IDLE;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = PRESSED;
                    deb_next   = '0;
                    long_next  = '0;
                    press_d    = 1'b1;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            PRESSED: begin
                // Saturation at LONG_LAST guarantees a single long pulse per press.
                if (long_cnt != LONG_LAST) begin
                    long_next = long_cnt + 1'b1;
                end
                if (long_cnt == LONG_PRE) begin
                    long_d = 1'b1;
                end
                if (key_s) begin
                    state_next = RELEASE_WAIT;
                    deb_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_next = PRESSED;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = IDLE;
                    deb_next   = '0;
                    release_d  = 1'b1;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                deb_next   = '0;
            end
        endcase
        level_d = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 240_000; stable-input cycles needed to accept a press or release (20 ms at 12 MHz).
REQ-002 Parameter LONG_CYC, default 12_000_000; debounced-pressed cycles before a long-press event (1 s at 12 MHz).
REQ-003 Port clk  input  1  single system clock (12 MHz PCLK); all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port key_n  input  1  raw push-button, active-low, asynchronous to clk, may bounce.
REQ-006 Port key_level  output  1  debounced level, 1 = pressed.
REQ-007 Port key_press  output  1  one-cycle pulse on accepted press.
REQ-008 Port key_release  output  1  one-cycle pulse on accepted release.
REQ-009 Port key_long  output  1  one-cycle pulse when a press has been held LONG_CYC cycles.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; only its output (key_s) feeds the logic.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-012 IDLE: key_s=0 -> PRESS_WAIT with debounce counter cleared; otherwise stay.
REQ-013 PRESS_WAIT: counter increments each cycle key_s=0; key_s=1 -> IDLE, counter cleared, no output pulse.
REQ-014 PRESS_WAIT: counter reaching DEBOUNCE_CYC-1 with key_s=0 -> PRESSED; key_press high for exactly the first cycle in PRESSED.
REQ-015 PRESSED: key_s=1 -> RELEASE_WAIT with debounce counter cleared.
REQ-016 RELEASE_WAIT: key_s=0 -> PRESSED with no new key_press; counter reaching DEBOUNCE_CYC-1 with key_s=1 -> IDLE; key_release high for exactly the first cycle in IDLE.
REQ-017 key_level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT; all outputs registered.
REQ-018 Long counter: cleared on entry to PRESSED from PRESS_WAIT; increments in PRESSED; holds its value in RELEASE_WAIT; saturates at LONG_CYC-1.
REQ-019 key_long SHALL pulse once, on the cycle the long counter first reaches LONG_CYC-1; no repeat pulses before the next accepted press.
REQ-020 Press latency: key_s low for DEBOUNCE_CYC consecutive cycles SHALL put key_press high 2 sync cycles + DEBOUNCE_CYC cycles after key_n first sampled low (+1 registered-output cycle), fixed and deterministic.
REQ-021 Counter widths SHALL be clog2 of their limits; no wrap-around under any input.
REQ-022 Legal parameters: DEBOUNCE_CYC >= 2, LONG_CYC > DEBOUNCE_CYC; other values unsupported.
REQ-023 key_press, key_release and key_long are mutually exclusive in any cycle; key_long never in the same cycle as key_press.

Reset
REQ-024 rst_n low SHALL immediately set synchronizer flops to 1, state to IDLE, both counters to 0, and all outputs to 0.
REQ-025 Reset mid-press SHALL generate no key_release; after reset, a still-held key is re-qualified as a new press through PRESS_WAIT.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20)
REQ-026 key_n held low 30 cycles, then high -> exactly one key_press, key_level=1, one key_long 19 cycles after key_press, one key_release ~6 cycles after key_n rises.
REQ-027 key_n toggles low/high every 2 cycles for 40 cycles -> no pulses; key_level stays 0.
REQ-028 Pressed key bounces high for 2 cycles mid-hold -> no key_release, no second key_press, key_level stays 1.
REQ-029 key_n held low 10 cycles, released -> key_press and key_release once each, key_long never.
REQ-030 rst_n pulsed low while key_level=1, key_n kept low -> outputs 0 at once; key_press again after sync + 4 cycles, no key_release.
